// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, enable-FSM states and ratio clamping for the clock divider
package clk_div_pkg;
  localparam int unsigned MIN_RATIO = 2;
  localparam int DEF_DIV_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, STOP} en_state_e;
  function automatic int unsigned clamp_ratio(input int unsigned r);
    return (r < MIN_RATIO) ? MIN_RATIO : r;
  endfunction
endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel with shadowed ratio, clean start/stop, odd-duty stretch and optional half-cycle phase
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W     = DEF_DIV_W,
  parameter int DEF_RATIO = 2,
  parameter bit PHASE_NEG = 1'b0,
  parameter bit ODD50     = 1'b1
) (
  input  logic             pll_clk,
  input  logic             Resetn,
  input  logic [DIV_W-1:0] ratio_i,
  input  logic             load_i,
  input  logic             en_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             ack_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, act_q, act_d, shadow_q, shadow_d, ld_val;
  logic pend_q, pend_d, raw_q, raw_d, tick_q, tick_d, ack_q, ack_d;
  logic tc, start, swap, run_d, base, str_q;
  en_state_e state_q, state_d;

  always_comb begin
    ld_val   = DIV_W'(clamp_ratio(32'(ratio_i)));
    tc       = state_q != IDLE && cnt_q == act_q - 1'b1;
    start    = state_q == IDLE && en_i;
    swap     = pend_q && (tc || start);
    act_d    = swap ? (load_i ? ld_val : shadow_q) : act_q;
    shadow_d = load_i ? ld_val : shadow_q;
    pend_d   = swap ? 1'b0 : (load_i | pend_q);
    state_d  = en_i ? RUN : ((state_q == IDLE || tc) ? IDLE : STOP);
    run_d    = state_d != IDLE;
    cnt_d    = (!run_d || tc || start) ? '0 : cnt_q + 1'b1;
    raw_d    = run_d && cnt_d < (act_d >> 1);
    tick_d   = run_d && cnt_d == '0;
    ack_d    = swap;
  end

  always_ff @(posedge pll_clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      act_q    <= DIV_W'(DEF_RATIO);
      shadow_q <= DIV_W'(DEF_RATIO);
      pend_q   <= 1'b0;
      raw_q    <= 1'b0;
      tick_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      raw_q    <= raw_d;
      tick_q   <= tick_d;
      ack_q    <= ack_d;
    end
  end

  // the stretch flop always sits on the edge opposite the base output so odd ratios gain exactly T/2
  if (PHASE_NEG) begin : g_neg
    logic base_q;
    always_ff @(negedge pll_clk or negedge Resetn) begin
      if (!Resetn) base_q <= 1'b0;
      else base_q <= raw_q;
    end
    always_ff @(posedge pll_clk or negedge Resetn) begin
      if (!Resetn) str_q <= 1'b0;
      else str_q <= base_q;
    end
    assign base = base_q;
  end else begin : g_pos
    always_ff @(negedge pll_clk or negedge Resetn) begin
      if (!Resetn) str_q <= 1'b0;
      else str_q <= raw_q;
    end
    assign base = raw_q;
  end

  assign clk_o  = base | (ODD50 && act_q[0] && str_q);
  assign tick_o = tick_q;
  assign ack_o  = ack_q;
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: NCH independent programmable clock dividers fed from pll_clk
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int             NCH       = 2,
  parameter int             DIV_W     = DEF_DIV_W,
  parameter int             DEF_RATIO = 2,
  parameter logic [NCH-1:0] PHASE_NEG = 2'b10,
  parameter bit             ODD50     = 1'b1
) (
  input  logic                 pll_clk,
  input  logic                 Resetn,
  input  logic [NCH*DIV_W-1:0] div_ratio,
  input  logic [NCH-1:0]       ratio_load,
  input  logic [NCH-1:0]       ch_en,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       update_ack
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W    (DIV_W),
      .DEF_RATIO(DEF_RATIO),
      .PHASE_NEG(PHASE_NEG[i]),
      .ODD50    (ODD50)
    ) u_ch (
      .pll_clk(pll_clk),
      .Resetn (Resetn),
      .ratio_i(div_ratio[i*DIV_W +: DIV_W]),
      .load_i (ratio_load[i]),
      .en_i   (ch_en[i]),
      .clk_o  (clk_out[i]),
      .tick_o (tick[i]),
      .ack_o  (update_ack[i])
    );
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: randomized and directed checks of clk_div_prog against a half-cycle waveform model
module tb_clk_div_prog;
  localparam int NCH = 2;
  localparam int W = 8;
  logic pll_clk = 1'b0;
  logic Resetn = 1'b1;
  logic [NCH*W-1:0] div_ratio = '0;
  logic [NCH-1:0] ratio_load = '0, ch_en = '0;
  logic [NCH-1:0] clk_out, tick, update_ack, clk_out_e, tick_e, update_ack_e;
  logic [NCH-1:0] pn = 2'b10;
  int n_tests = 0, n_fail = 0;

  always #5 pll_clk = ~pll_clk;

  clk_div_prog dut (
    .pll_clk(pll_clk), .Resetn(Resetn), .div_ratio(div_ratio), .ratio_load(ratio_load),
    .ch_en(ch_en), .clk_out(clk_out), .tick(tick), .update_ack(update_ack));
  clk_div_prog #(.ODD50(1'b0)) dut_e (
    .pll_clk(pll_clk), .Resetn(Resetn), .div_ratio(div_ratio), .ratio_load(ratio_load),
    .ch_en(ch_en), .clk_out(clk_out_e), .tick(tick_e), .update_ack(update_ack_e));

  // Model: each period is a start cycle plus a ratio; levels follow from the half-cycle position
  int cyc = 0;
  bit run[NCH], pend[NCH], prv[NCH], prv_e[NCH];
  int rr[NCH], sh[NCH], ps[NCH], ack_at[NCH];
  logic [NCH-1:0] e0, e1, e0e, e1e, et, ea;

  function automatic bit lvl(int h, int r, bit odd50, bit on);
    return on && h < (odd50 ? r : 2 * (r / 2));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      run[i] = 0; pend[i] = 0; prv[i] = 0; prv_e[i] = 0;
      rr[i] = 2; sh[i] = 2; ps[i] = 0; ack_at[i] = -1;
    end
    e0 = '0; e1 = '0; e0e = '0; e1e = '0; et = '0; ea = '0;
  endtask

  task automatic step();
    bit tc, sw, ld, en, b0, b1, c0, c1;
    int v, k;
    @(posedge pll_clk);
    cyc++;
    k = cyc;
    for (int i = 0; i < NCH; i++) begin
      ld = ratio_load[i];
      en = ch_en[i];
      v = int'(div_ratio[i*W +: W]);
      if (v < 2) v = 2;
      tc = run[i] && (k - 1 == ps[i] + rr[i] - 1);
      sw = pend[i] && (run[i] ? tc : en);
      if (sw) begin rr[i] = ld ? v : sh[i]; ack_at[i] = k; end
      if (ld) sh[i] = v;
      pend[i] = sw ? 1'b0 : (ld || pend[i]);
      if (run[i] ? tc : en) begin run[i] = en; ps[i] = k; end
      et[i] = run[i] && ps[i] == k;
      ea[i] = ack_at[i] == k;
      b0 = lvl(2 * (k - ps[i]), rr[i], 1'b1, run[i]);
      b1 = lvl(2 * (k - ps[i]) + 1, rr[i], 1'b1, run[i]);
      c0 = lvl(2 * (k - ps[i]), rr[i], 1'b0, run[i]);
      c1 = lvl(2 * (k - ps[i]) + 1, rr[i], 1'b0, run[i]);
      e0[i] = pn[i] ? prv[i] : b0;
      e1[i] = pn[i] ? b0 : b1;
      e0e[i] = pn[i] ? prv_e[i] : c0;
      e1e[i] = pn[i] ? c0 : c1;
      prv[i] = b1;
      prv_e[i] = c1;
    end
    #1;
  endtask

  task automatic test_reset();
    #3 Resetn = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({clk_out, clk_out_e, tick, tick_e, update_ack, update_ack_e} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got clk=%b/%b tick=%b ack=%b want all zero", clk_out, clk_out_e, tick, update_ack);
    end
    repeat (3) @(posedge pll_clk);
    @(negedge pll_clk); #1;
    n_tests++;
    if ({clk_out, clk_out_e, tick, update_ack} !== '0) begin
      n_fail++;
      $display("FAIL reset_held got clk=%b tick=%b ack=%b want zero", clk_out, tick, update_ack);
    end
    Resetn = 1'b1;
    ch_en = 2'b11;
    for (int n = 0; n < 20; n++) begin
      step();
      n_tests++;
      if ({clk_out, clk_out_e, tick, tick_e, update_ack, update_ack_e} !== {e0, e0e, et, et, ea, ea}) begin
        n_fail++;
        $display("FAIL default_div2 cyc=%0d got clk=%b/%b tick=%b ack=%b want clk=%b/%b tick=%b ack=%b", cyc, clk_out, clk_out_e, tick, update_ack, e0, e0e, et, ea);
      end
      @(negedge pll_clk); #1;
      n_tests++;
      if ({clk_out, clk_out_e} !== {e1, e1e}) begin
        n_fail++;
        $display("FAIL default_div2_neg cyc=%0d got clk=%b/%b want %b/%b", cyc, clk_out, clk_out_e, e1, e1e);
      end
    end
  endtask

  task automatic test_ratio_update();
    int acks = 0, ld_n = -1;
    for (int n = 0; n < 50; n++) begin
      step();
      if (ld_n >= 0 && n > ld_n && update_ack[0]) acks++;
      if (ld_n < 0 && n >= 10 && tick[0]) ld_n = n + 1;
      n_tests++;
      if ({clk_out, clk_out_e, tick, tick_e, update_ack, update_ack_e} !== {e0, e0e, et, et, ea, ea}) begin
        n_fail++;
        $display("FAIL ratio_update cyc=%0d got clk=%b/%b tick=%b ack=%b want clk=%b/%b tick=%b ack=%b", cyc, clk_out, clk_out_e, tick, update_ack, e0, e0e, et, ea);
      end
      @(negedge pll_clk); #1;
      n_tests++;
      if ({clk_out, clk_out_e} !== {e1, e1e}) begin
        n_fail++;
        $display("FAIL ratio_update_neg cyc=%0d got clk=%b/%b want %b/%b", cyc, clk_out, clk_out_e, e1, e1e);
      end
      ratio_load = '0;
      if (n == 0) begin div_ratio[7:0] = 8'd4; ratio_load = 2'b01; end
      if (n == ld_n) begin div_ratio[7:0] = 8'd7; ratio_load = 2'b01; end
      if (n == ld_n + 1) begin div_ratio[7:0] = 8'd5; ratio_load = 2'b01; end
    end
    n_tests++;
    if (acks !== 1) begin
      n_fail++;
      $display("FAIL ratio_update_ack_count got %0d want 1", acks);
    end
  endtask

  task automatic test_odd_duty();
    int hi = 0, hi_e = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (n >= 28) begin hi += int'(clk_out[0]); hi_e += int'(clk_out_e[0]); end
      n_tests++;
      if ({clk_out, clk_out_e, tick, tick_e, update_ack, update_ack_e} !== {e0, e0e, et, et, ea, ea}) begin
        n_fail++;
        $display("FAIL odd_duty cyc=%0d got clk=%b/%b tick=%b ack=%b want clk=%b/%b tick=%b ack=%b", cyc, clk_out, clk_out_e, tick, update_ack, e0, e0e, et, ea);
      end
      @(negedge pll_clk); #1;
      if (n >= 28) begin hi += int'(clk_out[0]); hi_e += int'(clk_out_e[0]); end
      n_tests++;
      if ({clk_out, clk_out_e} !== {e1, e1e}) begin
        n_fail++;
        $display("FAIL odd_duty_neg cyc=%0d got clk=%b/%b want %b/%b", cyc, clk_out, clk_out_e, e1, e1e);
      end
      ratio_load = '0;
      if (n == 0) begin div_ratio = {8'd3, 8'd3}; ratio_load = 2'b11; end
    end
    n_tests++;
    if (hi !== 12 || hi_e !== 8) begin
      n_fail++;
      $display("FAIL odd_duty_high_halves got %0d/%0d want 12/8", hi, hi_e);
    end
  endtask

  task automatic test_disable();
    int t_n = -1, ticks = 0, hi = 0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (t_n >= 0 && n >= t_n + 8) begin ticks += int'(tick[0]); hi += int'(clk_out[0]); end
      if (t_n < 0 && n >= 14 && tick[0]) t_n = n;
      n_tests++;
      if ({clk_out, clk_out_e, tick, tick_e, update_ack, update_ack_e} !== {e0, e0e, et, et, ea, ea}) begin
        n_fail++;
        $display("FAIL disable cyc=%0d got clk=%b/%b tick=%b ack=%b want clk=%b/%b tick=%b ack=%b", cyc, clk_out, clk_out_e, tick, update_ack, e0, e0e, et, ea);
      end
      @(negedge pll_clk); #1;
      n_tests++;
      if ({clk_out, clk_out_e} !== {e1, e1e}) begin
        n_fail++;
        $display("FAIL disable_neg cyc=%0d got clk=%b/%b want %b/%b", cyc, clk_out, clk_out_e, e1, e1e);
      end
      ratio_load = '0;
      if (n == 0) begin div_ratio[7:0] = 8'd6; ratio_load = 2'b01; end
      if (t_n >= 0 && n == t_n + 1) ch_en[0] = 1'b0;
    end
    n_tests++;
    if (t_n < 0 || ticks !== 0 || hi !== 0) begin
      n_fail++;
      $display("FAIL disable_quiet got start=%0d ticks=%0d high=%0d want start>=0 ticks=0 high=0", t_n, ticks, hi);
    end
  endtask

  task automatic test_clamp();
    int ticks = 0;
    ch_en = 2'b11;
    for (int n = 0; n < 580; n++) begin
      step();
      if (n >= 70) ticks += int'(tick[0]);
      n_tests++;
      if ({clk_out, clk_out_e, tick, tick_e, update_ack, update_ack_e} !== {e0, e0e, et, et, ea, ea}) begin
        n_fail++;
        $display("FAIL clamp cyc=%0d got clk=%b/%b tick=%b ack=%b want clk=%b/%b tick=%b ack=%b", cyc, clk_out, clk_out_e, tick, update_ack, e0, e0e, et, ea);
      end
      @(negedge pll_clk); #1;
      n_tests++;
      if ({clk_out, clk_out_e} !== {e1, e1e}) begin
        n_fail++;
        $display("FAIL clamp_neg cyc=%0d got clk=%b/%b want %b/%b", cyc, clk_out, clk_out_e, e1, e1e);
      end
      ratio_load = '0;
      if (n == 0) begin div_ratio = {8'd1, 8'd0}; ratio_load = 2'b11; end
      if (n == 20) begin div_ratio[7:0] = 8'd255; ratio_load = 2'b01; end
    end
    n_tests++;
    if (ticks !== 2) begin
      n_fail++;
      $display("FAIL clamp_255_ticks got %0d want 2", ticks);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    int ticks = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      step();
      n_tests++;
      if ({clk_out, clk_out_e, tick, update_ack} !== {e0, e0e, et, ea}) begin
        n_fail++;
        $display("FAIL reset_mid_pre cyc=%0d got clk=%b/%b want %b/%b", cyc, clk_out, clk_out_e, e0, e0e);
      end
      found = clk_out[0];
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_high got no high phase within 300 cycles want high");
    end
    #2 Resetn = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({clk_out, clk_out_e, tick, tick_e, update_ack, update_ack_e} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async got clk=%b/%b tick=%b ack=%b want zero", clk_out, clk_out_e, tick, update_ack);
    end
    @(negedge pll_clk); #1;
    Resetn = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step();
      ticks += int'(tick[0]);
      n_tests++;
      if ({clk_out, clk_out_e, tick, tick_e, update_ack, update_ack_e} !== {e0, e0e, et, et, ea, ea}) begin
        n_fail++;
        $display("FAIL reset_mid_restart cyc=%0d got clk=%b/%b tick=%b want clk=%b/%b tick=%b", cyc, clk_out, clk_out_e, tick, e0, e0e, et);
      end
      @(negedge pll_clk); #1;
    end
    n_tests++;
    if (ticks !== 6) begin
      n_fail++;
      $display("FAIL reset_mid_default_ratio ticks got %0d want 6", ticks);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      step();
      n_tests++;
      if ({clk_out, clk_out_e, tick, tick_e, update_ack, update_ack_e} !== {e0, e0e, et, et, ea, ea}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got clk=%b/%b tick=%b ack=%b want clk=%b/%b tick=%b ack=%b", cyc, clk_out, clk_out_e, tick, update_ack, e0, e0e, et, ea);
      end
      @(negedge pll_clk); #1;
      n_tests++;
      if ({clk_out, clk_out_e} !== {e1, e1e}) begin
        n_fail++;
        $display("FAIL random_neg cyc=%0d got clk=%b/%b want %b/%b", cyc, clk_out, clk_out_e, e1, e1e);
      end
      for (int i = 0; i < NCH; i++) begin
        ratio_load[i] = ($urandom_range(0, 7) == 0);
        div_ratio[i*W +: W] = 8'($urandom_range(0, 12));
        if ($urandom_range(0, 24) == 0) ch_en[i] = ~ch_en[i];
      end
    end
  endtask

  initial begin
    test_reset();
    test_ratio_update();
    test_odd_duty();
    test_disable();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
